// File: rtl/icache_line_filler.sv
// ICache line filler: queues fill requests and streams each line into the data SRAM.
// Optional ICFILL_CWF_EN selects critical-word-first bursts that wrap within the line.
module icache_line_filler #(
  parameter int BEATS   = 4,
  parameter int CADDR_W = 12,
  parameter int QDEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     IN_reqValid,
  input  logic [31:0]              IN_reqReadAddr,
  input  logic [CADDR_W-1:0]       IN_reqCacheAddr,
  input  logic [1:0]               IN_reqCacheID,
  output logic                     OUT_stall,
  output logic                     OUT_arValid,
  input  logic                     IN_arReady,
  output logic [31:0]              OUT_arAddr,
  input  logic                     IN_rValid,
  input  logic [31:0]              IN_rData,
  input  logic                     IN_rLast,
  output logic                     OUT_rReady,
  output logic                     OUT_cacheWE,
  output logic [CADDR_W-1:0]       OUT_cacheAddr,
  output logic [31:0]              OUT_cacheData,
  output logic                     OUT_xferValid,
  output logic [31:0]              OUT_xferAddr,
  output logic [$clog2(BEATS):0]   OUT_xferProgress,
  output logic [$clog2(BEATS)-1:0] OUT_xferStartWord,
  output logic                     OUT_done,
  output logic [1:0]               OUT_doneCacheID
);
  localparam int IW = $clog2(BEATS);
  localparam int PW = IW + 1;
  localparam int QW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = $clog2(QDEPTH + 1);
  localparam logic [PW-1:0] LAST_BEAT = PW'(BEATS - 1);
  localparam logic [CW-1:0] FULL      = CW'(QDEPTH);
  localparam logic [QW-1:0] PTR_MAX   = QW'(QDEPTH - 1);

  typedef struct packed {
    logic [31:0]        raddr;
    logic [CADDR_W-1:0] caddr;
    logic [1:0]         id;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t             state_q, state_d;
  req_t               buf_q [QDEPTH];
  logic [QW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [QW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  req_t               cur_q, cur_d;
  logic [PW-1:0]      prog_q, prog_d;
  logic               wr_v_q, wr_v_d;
  logic [31:0]        wr_data_q, wr_data_d;
  logic [CADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic               done_q, done_d;
  logic [1:0]         done_id_q, done_id_d;

  logic               enq;
  logic               pop;
  logic               beat;
  logic [IW-1:0]      start_w;
  logic               unused_bits;

  assign OUT_stall   = (cnt_q == FULL);
  assign enq         = IN_reqValid && !OUT_stall;
  assign OUT_arValid = (state_q == ADDR);
  assign OUT_rReady  = (state_q == DATA);
  assign beat        = OUT_rReady && IN_rValid;

`ifdef ICFILL_CWF_EN
  assign start_w    = cur_q.raddr[2 +: IW];
  assign OUT_arAddr = {cur_q.raddr[31:2], 2'b00};
`else
  assign start_w    = '0;
  assign OUT_arAddr = {cur_q.raddr[31:IW+2], {(IW+2){1'b0}}};
`endif

  assign OUT_xferAddr      = {cur_q.raddr[31:IW+2], {(IW+2){1'b0}}};
  assign OUT_xferStartWord = start_w;
  assign OUT_xferValid     = (state_q != IDLE);
  assign OUT_xferProgress  = prog_q;
  assign OUT_cacheWE       = wr_v_q;
  assign OUT_cacheAddr     = wr_addr_q;
  assign OUT_cacheData     = wr_data_q;
  assign OUT_done          = done_q;
  assign OUT_doneCacheID   = done_id_q;
  assign unused_bits = ^{cur_q.raddr[IW+1:0], cur_q.caddr[IW-1:0]};

  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    prog_d    = prog_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    wr_v_d    = beat;
    wr_data_d = wr_data_q;
    wr_addr_d = wr_addr_q;
    done_d    = 1'b0;
    done_id_d = done_id_q;
    pop       = 1'b0;

    if (enq) begin
      wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (|cnt_q) begin
          pop     = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (IN_arReady) state_d = DATA;
      end
      DATA: begin
        if (beat && prog_q == LAST_BEAT) state_d = DONE;
      end
      DONE: begin
        done_d    = 1'b1;
        done_id_d = cur_q.id;
        prog_d    = '0;
        // chain straight into the next burst when one is waiting
        if (|cnt_q) begin
          pop     = 1'b1;
          state_d = ADDR;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      cur_d    = buf_q[rd_ptr_q];
      rd_ptr_d = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
    end

    if (beat) begin
      prog_d    = prog_q + 1'b1;
      wr_data_d = IN_rData;
      wr_addr_d = {cur_q.caddr[CADDR_W-1:IW], start_w + prog_q[IW-1:0]};
    end

    cnt_d = cnt_q + CW'(enq) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      cur_q     <= '0;
      prog_q    <= '0;
      wr_v_q    <= 1'b0;
      wr_data_q <= '0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
      done_id_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      cur_q     <= cur_d;
      prog_q    <= prog_d;
      wr_v_q    <= wr_v_d;
      wr_data_q <= wr_data_d;
      wr_addr_q <= wr_addr_d;
      done_q    <= done_d;
      done_id_q <= done_id_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      buf_q[wr_ptr_q] <= '{IN_reqReadAddr, IN_reqCacheAddr, IN_reqCacheID};
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(IN_reqValid && OUT_stall))
        else $error("icache_line_filler: request while stalled");
      if (beat) begin
        assert (IN_rLast == (prog_q == LAST_BEAT))
          else $error("icache_line_filler: rLast disagrees with beat count");
      end
    end
  end
`endif

endmodule
